// File: rtl/trng_pkg.sv
// Shared definitions for the ring-oscillator race comparator TRNG.
// Holds the race FSM encoding and the default sizing of the block.
package trng_pkg;

    localparam int unsigned NPAIR_DEF = 4;
    localparam int unsigned CNT_W_DEF = 12;
    localparam int unsigned LIMIT_DEF = 1023;
    localparam int unsigned TMO_DEF   = 65535;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/trng_edge_cnt.sv
// Synchronises one asynchronous oscillator output, detects its rising edges
// and counts them while enabled; clr wipes the count and the edge history.
module trng_edge_cnt #(
    parameter int unsigned CNT_W = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ro,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             hist_q, hist_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             edge_det;

    always_comb begin
        sync1_d  = ro;
        sync2_d  = sync1_q;
        edge_det = sync2_q & ~hist_q;
        hist_d   = clr ? 1'b0 : sync2_q;
        cnt_d    = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && edge_det) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/trng_race_cmp.sv
// Races two ring oscillators of the selected pair to LIMIT edges; the winner
// (or a timeout) is latched and handed out as one random bit on capture.
module trng_race_cmp
    import trng_pkg::*;
#(
    parameter int unsigned NPAIR = NPAIR_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned LIMIT = LIMIT_DEF,
    parameter int unsigned TMO   = TMO_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NPAIR-1:0]         ro_a,
    input  logic [NPAIR-1:0]         ro_b,
    input  logic                     cmp_inc,
    input  logic                     cmp_rst,
    input  logic                     cmp_str,
    input  logic                     cmp_cap,
    output logic                     cmp_end,
    output logic [$clog2(NPAIR)-1:0] pair_sel,
    output logic                     rnd_bit,
    output logic                     rnd_valid,
    output logic                     rnd_err
);

    localparam int unsigned SelW = $clog2(NPAIR);
    localparam int unsigned TmoW = $clog2(TMO + 1);

    state_e            state_q, state_d;
    logic [SelW-1:0]   sel_q, sel_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              winner_q, winner_d;
    logic              err_q, err_d;
    logic              tie_q, tie_d;
    logic              rbit_q, rbit_d;
    logic              rerr_q, rerr_d;
    logic              rvalid_q, rvalid_d;
    logic [CNT_W-1:0]  cnt_a, cnt_b;
    logic              a_hit, b_hit, fin, tmo_hit, cnt_en;

    assign a_hit   = (cnt_a == CNT_W'(LIMIT));
    assign b_hit   = (cnt_b == CNT_W'(LIMIT));
    assign fin     = a_hit | b_hit;
    // Timeout fires in the cycle whose increment brings the counter to TMO.
    assign tmo_hit = (tmo_q == TmoW'(TMO - 1));
    assign cnt_en  = (state_q == StRun) && !fin && !tmo_hit;

    trng_edge_cnt #(.CNT_W(CNT_W)) u_cnt_a (
        .clock (clock),
        .reset (reset),
        .ro    (ro_a[sel_q]),
        .clr   (cmp_rst),
        .en    (cnt_en),
        .cnt   (cnt_a)
    );

    trng_edge_cnt #(.CNT_W(CNT_W)) u_cnt_b (
        .clock (clock),
        .reset (reset),
        .ro    (ro_b[sel_q]),
        .clr   (cmp_rst),
        .en    (cnt_en),
        .cnt   (cnt_b)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            tmo_q    <= '0;
            winner_q <= 1'b0;
            err_q    <= 1'b0;
            tie_q    <= 1'b0;
            rbit_q   <= 1'b0;
            rerr_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            tmo_q    <= tmo_d;
            winner_q <= winner_d;
            err_q    <= err_d;
            tie_q    <= tie_d;
            rbit_q   <= rbit_d;
            rerr_q   <= rerr_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cmp_rst) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (cmp_str) state_d = StRun;
                StRun:   if (fin || tmo_hit) state_d = StDone;
                StDone:  state_d = StDone;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        sel_d    = sel_q;
        tmo_d    = tmo_q;
        winner_d = winner_q;
        err_d    = err_q;
        tie_d    = tie_q;
        rbit_d   = rbit_q;
        rerr_d   = rerr_q;
        rvalid_d = 1'b0;
        if (cmp_rst) begin
            tmo_d    = '0;
            winner_d = 1'b0;
            err_d    = 1'b0;
        end else if (state_q == StRun) begin
            tmo_d = tmo_q + 1'b1;
            if (fin) begin
                err_d = 1'b0;
                if (a_hit && b_hit) begin
                    winner_d = tie_q;
                    tie_d    = ~tie_q;
                end else begin
                    winner_d = a_hit;
                end
            end else if (tmo_hit) begin
                winner_d = 1'b0;
                err_d    = 1'b1;
            end
        end
        if (cmp_inc && (state_q != StRun)) begin
            sel_d = sel_q + 1'b1;
        end
        if (cmp_cap && !cmp_rst && (state_q == StDone)) begin
            rbit_d   = winner_q;
            rerr_d   = err_q;
            rvalid_d = 1'b1;
        end
    end

    always_comb begin
        cmp_end   = (state_q == StDone);
        pair_sel  = sel_q;
        rnd_bit   = rbit_q;
        rnd_valid = rvalid_q;
        rnd_err   = rerr_q;
    end

endmodule

// File: tb/tb_trng_race_cmp.sv
// Directed bench for trng_race_cmp with LIMIT=8, TMO=100, NPAIR=4; oscillators
// are modelled as clock-derived square waves on one selected pair.
module tb_trng_race_cmp;

    localparam int unsigned NPAIR = 4;
    localparam int unsigned LIMIT = 8;
    localparam int unsigned TMO   = 100;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NPAIR-1:0] ro_a = '0;
    logic [NPAIR-1:0] ro_b = '0;
    logic             cmp_inc = 1'b0;
    logic             cmp_rst = 1'b0;
    logic             cmp_str = 1'b0;
    logic             cmp_cap = 1'b0;
    logic             cmp_end;
    logic [1:0]       pair_sel;
    logic             rnd_bit;
    logic             rnd_valid;
    logic             rnd_err;

    int checks = 0;
    int errors = 0;
    int a_per = 0;
    int b_per = 0;
    int osc_pair = 0;
    int osc_cnt = 0;

    trng_race_cmp #(
        .NPAIR (NPAIR),
        .CNT_W (12),
        .LIMIT (LIMIT),
        .TMO   (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ro_a      (ro_a),
        .ro_b      (ro_b),
        .cmp_inc   (cmp_inc),
        .cmp_rst   (cmp_rst),
        .cmp_str   (cmp_str),
        .cmp_cap   (cmp_cap),
        .cmp_end   (cmp_end),
        .pair_sel  (pair_sel),
        .rnd_bit   (rnd_bit),
        .rnd_valid (rnd_valid),
        .rnd_err   (rnd_err)
    );

    always #5 clock = ~clock;

    // Period 0 means stuck low; otherwise half high, half low.
    always @(negedge clock) begin
        osc_cnt = osc_cnt + 1;
        ro_a = '0;
        ro_b = '0;
        if (a_per != 0) ro_a[osc_pair] = ((osc_cnt % a_per) >= (a_per / 2));
        if (b_per != 0) ro_b[osc_pair] = ((osc_cnt % b_per) >= (b_per / 2));
    end

    task automatic start_race();
        @(negedge clock);
        cmp_rst = 1'b1;
        @(negedge clock);
        cmp_rst = 1'b0;
        cmp_str = 1'b1;
        @(negedge clock);
        cmp_str = 1'b0;
    endtask

    task automatic wait_end(input int bound, output int k);
        k = 0;
        while (!cmp_end && k < bound) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({cmp_end, pair_sel, rnd_bit, rnd_valid, rnd_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {cmp_end, pair_sel, rnd_bit, rnd_valid, rnd_err});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_pair_sel();
        logic [1:0] exp_sel;
        cmp_inc = 1'b1;
        repeat (3) @(negedge clock);
        cmp_inc = 1'b0;
        checks++;
        if (pair_sel !== 2'd3) begin
            errors++;
            $display("FAIL pair_sel_to_3: got %0d want 3", pair_sel);
        end
        for (int i = 0; i < 4; i++) begin
            cmp_inc = 1'b1;
            @(negedge clock);
            cmp_inc = 1'b0;
            exp_sel = 2'(i);
            checks++;
            if (pair_sel !== exp_sel) begin
                errors++;
                $display("FAIL pair_sel_step%0d: got %0d want %0d", i, pair_sel, exp_sel);
            end
        end
        a_per = 0;
        b_per = 0;
        start_race();
        cmp_inc = 1'b1;
        repeat (2) @(negedge clock);
        cmp_inc = 1'b0;
        checks++;
        if (pair_sel !== 2'd3) begin
            errors++;
            $display("FAIL pair_sel_run_hold: got %0d want 3", pair_sel);
        end
    endtask

    task automatic test_a_wins();
        int k;
        osc_pair = 3;
        a_per = 4;
        b_per = 6;
        start_race();
        cmp_cap = 1'b1;
        @(negedge clock);
        cmp_cap = 1'b0;
        checks++;
        if (rnd_valid !== 1'b0) begin
            errors++;
            $display("FAIL cap_in_run: got rnd_valid %b want 0", rnd_valid);
        end
        wait_end(80, k);
        k = k + 1;
        checks++;
        if (cmp_end !== 1'b1 || k < 29 || k > 40) begin
            errors++;
            $display("FAIL a_race_end: got cmp_end %b at cycle %0d want 1 within 29..40",
                     cmp_end, k);
        end
        cmp_cap = 1'b1;
        @(negedge clock);
        cmp_cap = 1'b0;
        checks++;
        if ({rnd_valid, rnd_bit, rnd_err, cmp_end} !== 4'b1101) begin
            errors++;
            $display("FAIL a_capture: got valid,bit,err,end %b want 1101",
                     {rnd_valid, rnd_bit, rnd_err, cmp_end});
        end
        @(negedge clock);
        checks++;
        if ({rnd_valid, rnd_bit, cmp_end} !== 3'b011) begin
            errors++;
            $display("FAIL a_valid_pulse_hold: got valid,bit,end %b want 011",
                     {rnd_valid, rnd_bit, cmp_end});
        end
    endtask

    task automatic test_tie();
        int k;
        a_per = 4;
        b_per = 4;
        for (int r = 0; r < 2; r++) begin
            start_race();
            wait_end(80, k);
            cmp_cap = 1'b1;
            @(negedge clock);
            cmp_cap = 1'b0;
            checks++;
            if ({cmp_end, rnd_valid, rnd_bit, rnd_err} !== {1'b1, 1'b1, r[0], 1'b0}) begin
                errors++;
                $display("FAIL tie_race%0d: got end,valid,bit,err %b want 11%b0",
                         r, {cmp_end, rnd_valid, rnd_bit, rnd_err}, r[0]);
            end
        end
    endtask

    task automatic test_timeout();
        int k;
        a_per = 0;
        b_per = 0;
        start_race();
        wait_end(200, k);
        checks++;
        if (k != 100) begin
            errors++;
            $display("FAIL timeout_cycle: got %0d want 100", k);
        end
        cmp_cap = 1'b1;
        @(negedge clock);
        cmp_cap = 1'b0;
        checks++;
        if ({rnd_valid, rnd_bit, rnd_err} !== 3'b101) begin
            errors++;
            $display("FAIL timeout_capture: got valid,bit,err %b want 101",
                     {rnd_valid, rnd_bit, rnd_err});
        end
    endtask

    task automatic test_cap_with_rst();
        int k;
        a_per = 4;
        b_per = 6;
        start_race();
        wait_end(80, k);
        checks++;
        if (cmp_end !== 1'b1) begin
            errors++;
            $display("FAIL caprst_done: got cmp_end %b want 1", cmp_end);
        end
        cmp_cap = 1'b1;
        cmp_rst = 1'b1;
        @(negedge clock);
        cmp_cap = 1'b0;
        cmp_rst = 1'b0;
        checks++;
        if ({rnd_valid, cmp_end, rnd_err} !== 3'b001) begin
            errors++;
            $display("FAIL caprst_result: got valid,end,err %b want 001",
                     {rnd_valid, cmp_end, rnd_err});
        end
    endtask

    task automatic test_reset_mid_run();
        logic seen_valid;
        a_per = 4;
        b_per = 0;
        start_race();
        repeat (22) @(negedge clock);
        checks++;
        if (cmp_end !== 1'b0) begin
            errors++;
            $display("FAIL midrun_still_running: got cmp_end %b want 0", cmp_end);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({cmp_end, pair_sel, rnd_bit, rnd_valid, rnd_err} !== 6'b0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got %b want 000000",
                     {cmp_end, pair_sel, rnd_bit, rnd_valid, rnd_err});
        end
        repeat (4) @(negedge clock);
        seen_valid = 1'b0;
        cmp_cap = 1'b1;
        @(negedge clock);
        cmp_cap = 1'b0;
        repeat (3) begin
            seen_valid = seen_valid | rnd_valid | cmp_end;
            @(negedge clock);
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_cap_after_reset: got valid_or_end %b want 0", seen_valid);
        end
    endtask

    initial begin
        test_reset();
        test_pair_sel();
        test_a_wins();
        test_tie();
        test_timeout();
        test_cap_with_rst();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
